// File: rtl/mpmc10_pkg.sv
// mpmc10 shared types for the read-response return path.
// Optional MPMC10_RD_BYTE_ZERO_EN adds byte selects to each read tag.
package mpmc10_pkg;

    localparam int unsigned MPMC10_LINE_W = 256;
    localparam int unsigned MPMC10_HALF_W = 128;

    typedef struct packed {
        logic [3:0]  cid;
        logic [4:0]  adr;
`ifdef MPMC10_RD_BYTE_ZERO_EN
        logic [15:0] sel;
`endif
    } mpmc10_rd_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOLD
    } mpmc10_rd_state_t;

    function automatic logic [MPMC10_HALF_W-1:0] rd_half(
        input logic [MPMC10_LINE_W-1:0] line,
        input logic                     hi
    );
        return hi ? line[255:128] : line[127:0];
    endfunction

endpackage

// File: rtl/mpmc10_read_resp_wb_if.sv
// Bundle of tag-request, memory-return and response handshakes.
// Master drives requests/returns, slave is the response block.
interface mpmc10_read_resp_wb_if #(
    parameter int WID = 16
) ();
    logic             req_v;
    logic             req_rdy;
    logic [3:0]       req_cid;
    logic [31:0]      req_adr;
    logic [WID-1:0]   req_sel;
    logic             mem_v;
    logic             mem_rdy;
    logic [255:0]     mem_dat;
    logic             out_v;
    logic             out_rdy;
    logic [3:0]       out_cid;
    logic [WID*8-1:0] out_dat;

    modport master (
        output req_v, req_cid, req_adr, req_sel,
        output mem_v, mem_dat, out_rdy,
        input  req_rdy, mem_rdy, out_v, out_cid, out_dat
    );

    modport slave (
        input  req_v, req_cid, req_adr, req_sel,
        input  mem_v, mem_dat, out_rdy,
        output req_rdy, mem_rdy, out_v, out_cid, out_dat
    );
endinterface

// File: rtl/mpmc10_rd_tag_fifo.sv
// Circular FIFO of pending read tags, QDEP entries (power of two).
// Push is ignored when full, pop is ignored when empty.
module mpmc10_rd_tag_fifo
    import mpmc10_pkg::*;
#(
    parameter int QDEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  mpmc10_rd_tag_t        din_i,
    output mpmc10_rd_tag_t        dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [$clog2(QDEP):0] count_o
);
    localparam int AW = $clog2(QDEP);
    localparam int CW = AW + 1;

    mpmc10_rd_tag_t mem_q [QDEP];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(QDEP));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer/count next state; pointers wrap naturally at QDEP.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage, written at the write pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end
endmodule

// File: rtl/mpmc10_read_resp_wb.sv
// Pairs in-order memory read lines with queued tags and registers the response.
// MPMC10_RD_BYTE_ZERO_EN: zero response bytes whose tag select bit is clear.
module mpmc10_read_resp_wb
    import mpmc10_pkg::*;
#(
    parameter int WID  = 16,
    parameter int QDEP = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mpmc10_read_resp_wb_if.slave      bus,
    output logic                      err
);
    localparam int CW = $clog2(QDEP) + 1;

    mpmc10_rd_state_t state_q, state_d;
    logic             out_v_q, out_v_d;
    logic [3:0]       out_cid_q, out_cid_d;
    logic [WID*8-1:0] out_dat_q, out_dat_d;
    logic             err_q, err_d;

    mpmc10_rd_tag_t   tag_in, tag_out;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt, cnt_nx;
    logic             mem_rdy, push, pop, undr;
    logic [127:0]     half;
    logic             unused_bits;

    assign tag_in.cid = bus.req_cid;
    assign tag_in.adr = bus.req_adr[4:0];
`ifdef MPMC10_RD_BYTE_ZERO_EN
    assign tag_in.sel = 16'(bus.req_sel);
    assign unused_bits = ^{bus.req_adr[31:5], tag_out.adr[3:0]};
`else
    assign unused_bits = ^{bus.req_adr[31:5], tag_out.adr[3:0],
                           bus.req_sel};
`endif

    assign mem_rdy = ~out_v_q | bus.out_rdy;
    assign push    = bus.req_v & ~fifo_full;
    assign pop     = bus.mem_v & mem_rdy & ~fifo_empty;
    assign undr    = bus.mem_v & mem_rdy & fifo_empty;
    assign cnt_nx  = fifo_cnt + CW'(push) - CW'(pop);

    mpmc10_rd_tag_fifo #(
        .QDEP (QDEP)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (tag_in),
        .dout_o  (tag_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Extract the addressed half line and optionally byte-qualify it.
    always_comb begin
        half = rd_half(bus.mem_dat, tag_out.adr[4]);
`ifdef MPMC10_RD_BYTE_ZERO_EN
        for (int b = 0; b < 16; b++) begin
            if (!tag_out.sel[b]) begin
                half[b*8 +: 8] = 8'h00;
            end
        end
`endif
    end

    // FSM next state and response register next values.
    always_comb begin
        state_d   = state_q;
        out_cid_d = out_cid_q;
        out_dat_d = out_dat_q;
        err_d     = err_q | undr;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = PEND;
            end
            PEND: begin
                if (pop) state_d = HOLD;
            end
            HOLD: begin
                if (pop) begin
                    state_d = HOLD;
                end else if (bus.out_rdy) begin
                    state_d = (cnt_nx != '0) ? PEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            out_cid_d = tag_out.cid;
            out_dat_d = (WID*8)'(half);
        end
        out_v_d = (state_d == HOLD);
    end

    // State, response and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_v_q   <= 1'b0;
            out_cid_q <= '0;
            out_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_v_q   <= out_v_d;
            out_cid_q <= out_cid_d;
            out_dat_q <= out_dat_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_rdy = ~fifo_full;
    assign bus.mem_rdy = mem_rdy;
    assign bus.out_v   = out_v_q;
    assign bus.out_cid = out_cid_q;
    assign bus.out_dat = out_dat_q;
    assign err         = err_q;
endmodule

// File: tb/tb_mpmc10_read_resp_wb.sv
// Randomized + directed bench for mpmc10_read_resp_wb against a queue model.
// Honors MPMC10_RD_BYTE_ZERO_EN the same way as the design build.
module tb_mpmc10_read_resp_wb;
    localparam int WID  = 16;
    localparam int QDEP = 4;

    typedef struct {
        logic [3:0]  cid;
        logic        hi;
        logic [15:0] sel;
    } tag_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int   n_cmp = 0;
    int   n_bad = 0;

    mpmc10_read_resp_wb_if #(.WID(WID)) bus ();

    mpmc10_read_resp_wb #(
        .WID  (WID),
        .QDEP (QDEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    tag_t         q[$];
    logic         ev = 1'b0;
    logic [3:0]   ecid = '0;
    logic [127:0] edat = '0;
    logic         eerr = 1'b0;
    bit           mvalid = 1'b0;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [127:0] mdl(tag_t t, logic [255:0] md);
        logic [127:0] h;
        h = t.hi ? md[255:128] : md[127:0];
`ifdef MPMC10_RD_BYTE_ZERO_EN
        for (int b = 0; b < 16; b++)
            if (!t.sel[b]) h[b*8 +: 8] = 8'h00;
`endif
        return h;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step(input logic rst, input logic rv, input logic [3:0] cid,
                        input logic [31:0] adr, input logic [15:0] sel,
                        input logic mv, input logic [255:0] md, input logic ordy);
        logic pushm;
        logic mr;
        tag_t t;
        @(negedge clk);
        rst_n       = ~rst;
        bus.req_v   = rv;
        bus.req_cid = cid;
        bus.req_adr = adr;
        bus.req_sel = sel;
        bus.mem_v   = mv;
        bus.mem_dat = md;
        bus.out_rdy = ordy;
        #1;
        if (mvalid) begin
            chk("req_rdy", 256'(bus.req_rdy), 256'(q.size() != QDEP));
            chk("mem_rdy", 256'(bus.mem_rdy), 256'(!ev || ordy));
            chk("out_v", 256'(bus.out_v), 256'(ev));
            if (ev) begin
                chk("out_cid", 256'(bus.out_cid), 256'(ecid));
                chk("out_dat", 256'(bus.out_dat), 256'(edat));
            end
            chk("err", 256'(err), 256'(eerr));
        end
        if (rst) begin
            q.delete();
            ev = 1'b0; ecid = '0; edat = '0; eerr = 1'b0;
            mvalid = 1'b1;
        end else begin
            pushm = rv && (q.size() != QDEP);
            mr = !ev || ordy;
            ev = ev && !ordy;
            if (mv && mr) begin
                if (q.size() == 0) begin
                    eerr = 1'b1;
                end else begin
                    t = q.pop_front();
                    ev = 1'b1;
                    ecid = t.cid;
                    edat = mdl(t, md);
                end
            end
            if (pushm) begin
                t.cid = cid; t.hi = adr[4]; t.sel = sel;
                q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 4'h0, 32'h0, 16'h0, 1'b0, 256'h0, ordy);
    endtask

    logic [255:0] md1;
    logic [255:0] md2;
    logic [127:0] x1;
    logic [127:0] x2;

    initial begin
        bus.req_v = 1'b0; bus.req_cid = '0; bus.req_adr = '0; bus.req_sel = '0;
        bus.mem_v = 1'b0; bus.mem_dat = '0; bus.out_rdy = 1'b0;

        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_out_v", 256'(bus.out_v), 256'(0));
        chk("rst_out_cid", 256'(bus.out_cid), 256'(0));
        chk("rst_out_dat", 256'(bus.out_dat), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_req_rdy", 256'(bus.req_rdy), 256'(1));
        chk("rst_mem_rdy", 256'(bus.mem_rdy), 256'(1));

        // single read, high half, sel 00FF
        md1 = {128'h0123456789abcdef_fedcba9876543210,
               128'h1111_2222_3333_4444_5555_6666_7777_8888};
`ifdef MPMC10_RD_BYTE_ZERO_EN
        x1 = 128'h0000000000000000_fedcba9876543210;
`else
        x1 = 128'h0123456789abcdef_fedcba9876543210;
`endif
        step(0, 1, 4'd3, 32'h10, 16'h00ff, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, md1, 0);
        chk("single_v", 256'(bus.out_v), 256'(1));
        chk("single_cid", 256'(bus.out_cid), 256'(3));
        chk("single_dat", 256'(bus.out_dat), 256'(x1));
        idle(1);
        chk("single_done", 256'(bus.out_v), 256'(0));

        // low half, sel 0001
        md2 = {128'hffff_eeee_dddd_cccc_bbbb_aaaa_9999_8888,
               128'h00112233445566778899aabbccddeeff};
`ifdef MPMC10_RD_BYTE_ZERO_EN
        x2 = 128'h000000000000000000000000000000ff;
`else
        x2 = 128'h00112233445566778899aabbccddeeff;
`endif
        step(0, 1, 4'd7, 32'h0000_1200, 16'h0001, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, md2, 1);
        chk("low_dat", 256'(bus.out_dat), 256'(x2));
        idle(1);

        // fill queue, then pop with refused push
        for (int i = 0; i < 4; i++)
            step(0, 1, 4'(8 + i), $urandom, 16'hffff, 0, 0, 1);
        chk("full_req_rdy", 256'(bus.req_rdy), 256'(0));
        step(0, 1, 4'd15, 0, 16'hffff, 1, rnd256(), 1);
        chk("after_pop_rdy", 256'(bus.req_rdy), 256'(1));
        chk("after_pop_cid", 256'(bus.out_cid), 256'(8));
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, rnd256(), 1);
            chk("drain_cid", 256'(bus.out_cid), 256'(9 + i));
        end
        idle(1);
        chk("drain_v", 256'(bus.out_v), 256'(0));
        chk("drain_err", 256'(err), 256'(0));

        // backpressure
        step(0, 1, 4'd5, $urandom, 16'hffff, 0, 0, 0);
        step(0, 1, 4'd6, $urandom, 16'hffff, 0, 0, 0);
        md1 = rnd256();
        step(0, 0, 0, 0, 0, 1, md1, 0);
        chk("bp_cid1", 256'(bus.out_cid), 256'(5));
        x1 = bus.out_dat;
        step(0, 0, 0, 0, 0, 1, rnd256(), 0);
        chk("bp_mem_rdy", 256'(bus.mem_rdy), 256'(0));
        chk("bp_hold_cid", 256'(bus.out_cid), 256'(5));
        chk("bp_hold_dat", 256'(bus.out_dat), 256'(x1));
        step(0, 0, 0, 0, 0, 1, rnd256(), 1);
        chk("bp_cid2", 256'(bus.out_cid), 256'(6));
        idle(1);

        // streaming with wrap
        for (int k = 0; k <= 8; k++) begin
            step(0, k < 8, 4'(k), $urandom, 16'($urandom), k > 0, rnd256(), 1);
            if (k > 0) begin
                chk("stream_v", 256'(bus.out_v), 256'(1));
                chk("stream_cid", 256'(bus.out_cid), 256'(k - 1));
            end
        end
        idle(1);

        // underflow, sticky, cleared by reset
        step(0, 0, 0, 0, 0, 1, rnd256(), 1);
        chk("undr_err", 256'(err), 256'(1));
        chk("undr_v", 256'(bus.out_v), 256'(0));
        idle(1);
        chk("undr_sticky", 256'(err), 256'(1));
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("undr_clr", 256'(err), 256'(0));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic mv;
            mv = (q.size() != 0) ? ($urandom_range(0, 3) != 0)
                                 : ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom), $urandom, 16'($urandom), mv, rnd256(),
                 $urandom_range(0, 3) != 0);
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mpmc10_read_resp_wb.md
# mpmc10_read_resp_wb

Read-response return path of an mpmc10 Wishbone channel, the read-side counterpart of the write-mask stage. It records the tag (channel id, address low bits, byte selects) of each read issued to memory. It pairs in-order 256-bit memory read returns with those tags, extracts and byte-qualifies the addressed 128-bit half, and presents the result to the channel through a registered valid/ready output. It sits between the mpmc10 memory-side read data path and the per-channel Wishbone responder.

## Interface
Parameters:
- WID, 16, byte-lane count of the channel data path (channel data = WID*8 bits)
- QDEP, 4, pending-read tag queue depth (power of two, 2..16)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_v  in  1  read issued to memory this cycle; tag inputs valid
- req_rdy  out  1  tag queue can accept (not full)
- req_cid  in  4  channel id of the read
- req_adr  in  32  byte address of the read; only [4:0] retained
- req_sel  in  WID  byte selects of the read
- mem_v  in  1  memory read data valid
- mem_rdy  out  1  block accepts memory data this cycle
- mem_dat  in  256  memory read line
- out_v  out  1  response valid
- out_rdy  in  1  downstream accepts response
- out_cid  out  4  channel id of response
- out_dat  out  WID*8  response data
- err  out  1  sticky: memory data arrived with empty tag queue

## Operation
- Tag queue: circular FIFO, QDEP entries, rd/wr pointers plus count of width $clog2(QDEP)+1.
- Push on req_v & req_rdy; req_rdy = (count != QDEP). No bypass: a full queue with a pop that cycle still deasserts req_rdy.
- Pop on mem_v & mem_rdy & (count != 0).
- Simultaneous push and pop: both occur, count unchanged, pointers wrap modulo QDEP.
- mem_rdy = !out_v | out_rdy.
- State machine, states IDLE, PEND and HOLD:
  - IDLE (count==0, !out_v). Push -> PEND.
  - PEND (count>0, !out_v). Accepted mem data -> HOLD.
  - HOLD (out_v). out_rdy with no new data: -> PEND if count>0 after the cycle, else IDLE. out_rdy with accepted data: stay in HOLD with the new response.
- Data extraction on pop:
  - Half select: line half = mem_dat[255:128] if tag adr[4]==1, else mem_dat[127:0].
  - Byte qualification: per Configuration.
  - out_cid = tag cid.
- Underflow: mem_v with count==0 while mem_rdy=1. Data is dropped, err is set and holds until reset, and out_v is unaffected.
- Same-cycle req_v and mem_v with an empty queue counts as underflow. The tag is still pushed.

## Timing
- Reset values: out_v=0, out_cid=0, out_dat=0, err=0, count=0, pointers=0, state=IDLE. req_rdy=1 and mem_rdy=1 the cycle after reset.
- Reset mid-operation discards all queued tags and any held response.
- Latency is one cycle: mem data accepted in cycle N gives out_v=1 with that data in cycle N+1.
- out_v, out_cid and out_dat are registered and stay stable while out_v & !out_rdy.
- Full throughput is one response per cycle when out_rdy is held high.
- req_rdy and mem_rdy are combinational from registered state and out_rdy only.

## Configuration
- MPMC10_RD_BYTE_ZERO_EN defined: output bytes whose tag sel bit is 0 are forced to 8'h00.
- Undefined: the selected half is passed unmodified and sel is not stored. Each queue entry shrinks by WID bits.

## Structure
- mpmc10_pkg gains:
  - mpmc10_rd_tag_t, a packed struct of cid[3:0], adr[4:0] and sel[15:0]; sel is present only under MPMC10_RD_BYTE_ZERO_EN.
  - mpmc10_rd_state_t enum {IDLE, PEND, HOLD}.
- Sub-module mpmc10_rd_tag_fifo: parameterized QDEP-entry FIFO of mpmc10_rd_tag_t with push/pop/full/empty/count.
- The top level holds the FSM, extraction and output register.

## Test plan
- Single read, macro defined: push cid=3, adr=0x10, sel=16'h00FF. Next cycle, mem_dat high half = 128'h0123..EF. Required: the following cycle out_v=1, out_cid=3, out_dat low 8 bytes from the high half and upper 8 bytes 0.
- Fill queue: push 4 tags with no mem data. Required: req_rdy=0 after the 4th push. One mem return then restores req_rdy=1 one cycle later, and a same-cycle push while full is refused.
- Backpressure: hold out_rdy=0 with 2 pending tags and mem_v=1. Required: out_v stays 1 with data stable, mem_rdy=0, and the second return is accepted only in the cycle out_rdy=1.
- Streaming: 8 back-to-back reads with out_rdy=1 and mem_v one cycle behind. Required: 8 consecutive out_v cycles, cids in issue order, correct pointer wrap.
- Underflow: mem_v=1 with an empty queue. Required: err=1 next cycle and sticky, out_v=0. rst_n=0 for one cycle clears err.
- Macro undefined: sel=16'h0001, adr[4]=0. Required: out_dat equals mem_dat[127:0] in full.
